// File: rtl/gpio_pattern_gen_if.sv
// Control and pattern bus for gpio_pattern_gen; the controller drives master, the generator sits on slave.
interface gpio_pattern_gen_if #(
  parameter int WIDTH = 32,
  parameter int DIV_W = 24
);
  logic             en;
  logic [1:0]       mode;
  logic [DIV_W-1:0] div;
  logic [WIDTH-1:0] seed;
  logic             load;
  logic             step_once;
  logic [WIDTH-1:0] pattern;
  logic             tick;
  logic             wrap;

  modport master (
    output en, mode, div, seed, load, step_once,
    input  pattern, tick, wrap
  );

  modport slave (
    input  en, mode, div, seed, load, step_once,
    output pattern, tick, wrap
  );
endinterface

// File: rtl/gpio_pattern_gen.sv
// Prescaled GPIO pattern generator: rotate-left/right, bounce and count-up modes.
// pattern changes on the step edge; tick/wrap are registered and coincide with the new pattern.
module gpio_pattern_gen #(
  parameter int               WIDTH         = 32,
  parameter int               DIV_W         = 24,
  parameter logic [WIDTH-1:0] RESET_PATTERN = {{(WIDTH-1){1'b1}}, 1'b0}
) (
  input logic              clk,
  input logic              rst,
  gpio_pattern_gen_if.slave bus
);

  localparam int SC_W = $clog2(WIDTH);
  localparam logic [SC_W-1:0] SC_ROT_LAST = SC_W'(WIDTH - 1);
  localparam logic [SC_W-1:0] SC_BNC_LAST = SC_W'(WIDTH - 2);

  localparam logic [1:0] MODE_ROTL  = 2'b00;
  localparam logic [1:0] MODE_ROTR  = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_COUNT = 2'b11;

  typedef enum logic {DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1} dir_t;

  logic [WIDTH-1:0] pattern_q, pattern_d;
  logic [DIV_W-1:0] pcnt_q, pcnt_d;
  logic [SC_W-1:0]  sc_q, sc_d;
  dir_t             dir_q, dir_d;
  logic [1:0]       mode_q;
  logic             tick_q, wrap_q, wrap_d;
  logic             pre_step, mode_chg, step;
  logic [WIDTH-1:0] rot_left, rot_right;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern_q <= RESET_PATTERN;
      pcnt_q    <= '0;
      sc_q      <= '0;
      dir_q     <= DIR_LEFT;
      mode_q    <= MODE_ROTL;
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      pcnt_q    <= pcnt_d;
      sc_q      <= sc_d;
      dir_q     <= dir_d;
      mode_q    <= bus.mode;
      tick_q    <= step;
      wrap_q    <= wrap_d;
    end
  end

  // Step decode: prescaler, single-step, and the load / mode-change suppressions
  always_comb begin
    pcnt_d   = pcnt_q;
    pre_step = 1'b0;
    if (bus.en) begin
      if (pcnt_q >= bus.div) begin
        pre_step = 1'b1;
        pcnt_d   = '0;
      end else begin
        pcnt_d = pcnt_q + 1'b1;
      end
    end else begin
      pre_step = bus.step_once;
    end
    if (bus.load) begin
      pcnt_d = '0;
    end
    mode_chg = (bus.mode != mode_q);
    step     = pre_step && !bus.load && !mode_chg;
  end

  assign rot_left  = {pattern_q[WIDTH-2:0], pattern_q[WIDTH-1]};
  assign rot_right = {pattern_q[0], pattern_q[WIDTH-1:1]};

  // Next-state: pattern, step counter and bounce direction
  always_comb begin
    pattern_d = pattern_q;
    sc_d      = sc_q;
    dir_d     = dir_q;
    wrap_d    = 1'b0;
    if (bus.load) begin
      pattern_d = bus.seed;
      sc_d      = '0;
      dir_d     = DIR_LEFT;
    end else if (mode_chg) begin
      sc_d  = '0;
      dir_d = DIR_LEFT;
    end else if (step) begin
      case (mode_q)
        MODE_ROTL, MODE_ROTR: begin
          pattern_d = (mode_q == MODE_ROTL) ? rot_left : rot_right;
          wrap_d    = (sc_q == SC_ROT_LAST);
          sc_d      = (sc_q == SC_ROT_LAST) ? '0 : sc_q + 1'b1;
        end
        MODE_BOUNCE: begin
          pattern_d = (dir_q == DIR_LEFT) ? rot_left : rot_right;
          if (sc_q == SC_BNC_LAST) begin
            sc_d   = '0;
            dir_d  = (dir_q == DIR_LEFT) ? DIR_RIGHT : DIR_LEFT;
            wrap_d = (dir_q == DIR_RIGHT);
          end else begin
            sc_d = sc_q + 1'b1;
          end
        end
        default: begin
          pattern_d = pattern_q + 1'b1;
          wrap_d    = &pattern_q;
        end
      endcase
    end
  end

  // Outputs come straight from flops
  assign bus.pattern = pattern_q;
  assign bus.tick    = tick_q;
  assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_gpio_pattern_gen.sv
// Bench for gpio_pattern_gen: vector table of load/run cases plus scoreboarded multi-cycle sequences.
module tb_gpio_pattern_gen;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gpio_pattern_gen_if #(.WIDTH(8),  .DIV_W(8))  b8 ();
  gpio_pattern_gen_if #(.WIDTH(32), .DIV_W(24)) b32 ();

  gpio_pattern_gen #(.WIDTH(8), .DIV_W(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (b8)
  );

  gpio_pattern_gen #(.WIDTH(32), .DIV_W(24)) dut32 (
    .clk (clk),
    .rst (rst),
    .bus (b32)
  );

  typedef struct {
    logic [1:0] mode;
    logic [7:0] seed;
    logic [7:0] div;
    int         nsteps;
    logic [7:0] exp_pat;
    int         exp_wraps;
  } vec_t;

  typedef struct {
    logic [7:0] pat;
    logic       wrap;
  } exp_t;

  vec_t vecs[10];
  exp_t sbq[$];
  bit   sb_on = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   tick_cnt = 0;
  int   wrap_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] pat, input logic wrap);
    exp_t e;
    e.pat  = pat;
    e.wrap = wrap;
    sbq.push_back(e);
  endtask

  // Advance one clock and check the 8-bit DUT's tick/wrap against the scoreboard
  task automatic cyc();
    exp_t e;
    @(posedge clk);
    #1;
    if (!rst) begin
      chk("wrap_implies_tick", {63'd0, b8.wrap & ~b8.tick}, 64'd0);
      if (b8.tick) begin
        tick_cnt++;
        if (b8.wrap) wrap_cnt++;
        if (sb_on) begin
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_extra_tick: got tick with pattern 0x%0h, expected no tick", b8.pattern);
          end else begin
            e = sbq.pop_front();
            chk("sb_pattern", b8.pattern, e.pat);
            chk("sb_wrap", b8.wrap, e.wrap);
          end
        end
      end
    end
  endtask

  task automatic load8(input logic [1:0] mode, input logic [7:0] seed, input logic [7:0] div);
    b8.en   = 1'b0;
    b8.mode = mode;
    b8.seed = seed;
    b8.div  = div;
    b8.load = 1'b1;
    cyc();
    b8.load = 1'b0;
    cyc();
  endtask

  initial begin
    int t0, w0, cnt;
    logic [7:0]  p;
    logic [31:0] e32;

    vecs[0] = '{2'd0, 8'h01, 8'd0, 3,  8'h08, 0};
    vecs[1] = '{2'd0, 8'h81, 8'd2, 8,  8'h81, 1};
    vecs[2] = '{2'd1, 8'h01, 8'd1, 1,  8'h80, 0};
    vecs[3] = '{2'd1, 8'h96, 8'd0, 16, 8'h96, 2};
    vecs[4] = '{2'd2, 8'h01, 8'd0, 14, 8'h01, 1};
    vecs[5] = '{2'd2, 8'h01, 8'd0, 7,  8'h80, 0};
    vecs[6] = '{2'd2, 8'h01, 8'd0, 10, 8'h10, 0};
    vecs[7] = '{2'd3, 8'hFE, 8'd0, 2,  8'h00, 1};
    vecs[8] = '{2'd3, 8'h10, 8'd3, 5,  8'h15, 0};
    vecs[9] = '{2'd3, 8'hF0, 8'd0, 16, 8'h00, 1};

    rst = 1'b1;
    b8.en = 1'b0; b8.mode = 2'd0; b8.div = '0; b8.seed = '0; b8.load = 1'b0; b8.step_once = 1'b0;
    b32.en = 1'b0; b32.mode = 2'd0; b32.div = '0; b32.seed = '0; b32.load = 1'b0; b32.step_once = 1'b0;
    cyc();
    cyc();
    chk("rst_pattern8", b8.pattern, 8'hFE);
    chk("rst_tick8", b8.tick, 1'b0);
    chk("rst_wrap8", b8.wrap, 1'b0);
    chk("rst_pattern32", b32.pattern, 32'hFFFF_FFFE);
    rst = 1'b0;
    cyc();

    // Table: load seed, run exactly nsteps prescaled steps, compare final state
    foreach (vecs[k]) begin
      load8(vecs[k].mode, vecs[k].seed, vecs[k].div);
      t0 = tick_cnt;
      w0 = wrap_cnt;
      b8.en = 1'b1;
      repeat (vecs[k].nsteps * (int'(vecs[k].div) + 1)) cyc();
      b8.en = 1'b0;
      cyc();
      chk($sformatf("vec%0d_pattern", k), b8.pattern, vecs[k].exp_pat);
      chk($sformatf("vec%0d_ticks", k), tick_cnt - t0, vecs[k].nsteps);
      chk($sformatf("vec%0d_wraps", k), wrap_cnt - w0, vecs[k].exp_wraps);
    end

    // Bounce full cycle from 0x01, every tick scoreboarded
    sb_on = 1'b1;
    load8(2'd2, 8'h01, 8'd0);
    p = 8'h01;
    for (int i = 0; i < 7; i++) begin p = p << 1; push(p, 1'b0); end
    for (int i = 0; i < 7; i++) begin p = p >> 1; push(p, i == 6); end
    b8.en = 1'b1;
    repeat (14) cyc();
    b8.en = 1'b0;
    cyc();
    chk("bounce_drain", sbq.size(), 0);

    // Single-step while disabled; prescaler count must survive
    load8(2'd1, 8'h80, 8'd3);
    b8.en = 1'b1;
    cyc();
    cyc();
    chk("pre_single_no_step", b8.pattern, 8'h80);
    b8.en = 1'b0;
    push(8'h40, 1'b0); push(8'h20, 1'b0); push(8'h10, 1'b0);
    t0 = tick_cnt;
    for (int i = 0; i < 3; i++) begin
      b8.step_once = 1'b1;
      cyc();
      b8.step_once = 1'b0;
      cyc();
    end
    chk("single_ticks", tick_cnt - t0, 3);
    chk("single_pattern", b8.pattern, 8'h10);
    push(8'h08, 1'b0);
    b8.en = 1'b1;
    cyc();
    chk("pcnt_held_a", b8.pattern, 8'h10);
    cyc();
    chk("pcnt_held_b", b8.pattern, 8'h08);
    b8.en = 1'b0;
    cyc();
    chk("single_drain", sbq.size(), 0);

    // Load beats a coincident step; a mode switch drops that cycle's step
    b8.mode = 2'd0; b8.seed = 8'h5A; b8.div = 8'd0; b8.en = 1'b1; b8.load = 1'b1;
    cyc();
    b8.load = 1'b0;
    chk("load_pattern", b8.pattern, 8'h5A);
    chk("load_no_tick", b8.tick, 1'b0);
    push(8'hB4, 1'b0);
    cyc();
    chk("post_load_tick", b8.tick, 1'b1);
    b8.mode = 2'd1;
    cyc();
    chk("modesw_hold", b8.pattern, 8'hB4);
    chk("modesw_no_tick", b8.tick, 1'b0);
    push(8'h5A, 1'b0);
    cyc();
    chk("modesw_rotr", b8.pattern, 8'h5A);
    b8.en = 1'b0;
    cyc();
    chk("modesw_drain", sbq.size(), 0);
    sb_on = 1'b0;

    // Asynchronous reset mid-run at div=2, then full prescale period after release
    load8(2'd0, 8'h01, 8'd2);
    b8.en = 1'b1;
    repeat (3) cyc();
    chk("pre_rst_tick", b8.tick, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_pattern", b8.pattern, 8'hFE);
    chk("rst_async_tick", b8.tick, 1'b0);
    cyc();
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      chk($sformatf("rel_tick_%0d", i), b8.tick, i == 3);
    end
    chk("rel_pattern", b8.pattern, 8'hFD);
    b8.en = 1'b0;

    // 32-bit rotate-left from reset: tick every 4 cycles, wrap on 32nd tick
    b32.div = 24'd3;
    b32.en  = 1'b1;
    e32 = 32'hFFFF_FFFE;
    for (int n = 1; n <= 32; n++) begin
      e32 = {e32[30:0], e32[31]};
      cnt = 0;
      do begin
        cyc();
        cnt++;
      end while (!b32.tick && cnt < 8);
      chk($sformatf("w32_interval_%0d", n), cnt, 4);
      chk($sformatf("w32_pattern_%0d", n), b32.pattern, e32);
      chk($sformatf("w32_wrap_%0d", n), b32.wrap, n == 32);
    end
    b32.en = 1'b0;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gpio_pattern_gen.md
GPIO_PATTERN_GEN -- requirements
Module: gpio_pattern_gen

Interface
REQ-001 Parameter WIDTH, default 32: pattern register width (2..64).
REQ-002 Parameter DIV_W, default 24: prescaler counter and divisor width.
REQ-003 Parameter RESET_PATTERN, default {WIDTH-1 ones, 1'b0}: pattern value at reset.
REQ-004 clk  input  1: clock; all state is clocked on the rising edge.
REQ-005 rst  input  1: reset, asynchronous, active-high.
REQ-006 en  input  1: free-run enable for prescaled stepping.
REQ-007 mode  input  2: 00 rotate-left, 01 rotate-right, 10 bounce, 11 binary count-up.
REQ-008 div  input  DIV_W: prescaler terminal value; the step period is div+1 cycles.
REQ-009 seed  input  WIDTH: value captured by load.
REQ-010 load  input  1: synchronous load strobe.
REQ-011 step_once  input  1: single-step strobe, honoured only while en=0.
REQ-012 pattern  output  WIDTH: registered pattern, driven straight from a flop.
REQ-013 tick  output  1: one-cycle strobe marking each pattern advance.
REQ-014 wrap  output  1: one-cycle strobe marking completion of a full mode cycle.

Function
REQ-015 Prescaler: pcnt (DIV_W bits) increments each cycle while en=1; when pcnt>=div, the block issues a step and pcnt returns to 0.
REQ-016 With div=0 and en=1, a step occurs every cycle.
REQ-017 Lowering div below the current pcnt causes a step on the next cycle (>= compare); there is no lockout.
REQ-018 en=0 holds pcnt and pattern; step_once=1 with en=0 forces one step that cycle and leaves pcnt unchanged.
REQ-019 A step updates pattern on the same clock edge; tick is registered and is high the cycle after that edge (1-cycle latency, coincident with the new pattern).
REQ-020 Rotate-left: pattern <= {pattern[WIDTH-2:0], pattern[WIDTH-1]}.
REQ-021 Rotate-right: pattern <= {pattern[0], pattern[WIDTH-1:1]}.
REQ-022 Bounce: rotate in direction dir (reset: left); step counter sc counts 0..WIDTH-2; on the step where sc=WIDTH-2, dir toggles and sc returns to 0.
REQ-023 Count-up: pattern <= pattern+1, modulo 2^WIDTH.
REQ-024 wrap, rotate modes: sc counts 0..WIDTH-1; wrap is asserted with the tick of the step where sc returns to 0 (every WIDTH steps).
REQ-025 wrap, bounce mode: asserted with the tick of the step where dir returns to left (every 2*(WIDTH-1) steps).
REQ-026 wrap, count mode: asserted with the tick of the step where pattern goes from all-ones to 0.
REQ-027 load=1: pattern <= seed, pcnt <= 0, sc <= 0, dir <= left; no tick or wrap is issued; load has priority over any simultaneous step.
REQ-028 Mode change: mode is registered each cycle; when it differs from the registered value, sc <= 0 and dir <= left, pattern is held, and any step that cycle is dropped.
REQ-029 tick and wrap never assert in a cycle without a preceding step; wrap implies tick.

Reset
REQ-030 While rst=1: pattern=RESET_PATTERN, pcnt=0, sc=0, dir=left, tick=0, wrap=0, registered mode=00, effective immediately (asynchronous).
REQ-031 Reset asserted mid-step overrides the step; the first step after release requires a full div+1 enabled cycles.

Verification
REQ-032 WIDTH=32, div=3, en=1, mode=00 from reset -> tick every 4 cycles; pattern goes 0xFFFFFFFE -> 0xFFFFFFFD -> 0xFFFFFFFB; wrap on the 32nd tick with pattern=0xFFFFFFFE.
REQ-033 WIDTH=8, div=0, mode=10, load seed=0x01 -> pattern sequence 01,02,...,80,40,...,01; wrap with the 14th tick.
REQ-034 WIDTH=8, mode=11, load seed=0xFE, div=0 -> pattern FE, FF, 00; wrap with the 00 tick only.
REQ-035 en=0, step_once pulse x3, mode=01, pattern=0x80 (WIDTH=8) -> 40, 20, 10; exactly 3 ticks; pcnt unchanged.
REQ-036 load and a prescaler step in the same cycle -> pattern=seed, no tick; mode switch 00->01 mid-run -> no step that cycle, next step rotates right.
REQ-037 rst pulse while running at div=2 -> outputs return to reset values immediately; first tick comes 3 cycles after release.
